// File: rtl/logicap_pkg.sv
// logicap_pkg: shared types and default sizing for the logic-analyser/pattern
// blocks.
//   pattern_gen_state_t : playback FSM states of pattern_gen
//   default_size        : sample word / output pin vector width
//   default_max_div     : sample-period divider range
//   default_saddr_w     : sample-count width
package logicap_pkg;

  localparam int unsigned default_size    = 32;
  localparam int unsigned default_max_div = 32;
  localparam int unsigned default_saddr_w = 24;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    RUN,
    DONE
  } pattern_gen_state_t;

endpackage

// File: rtl/sample_ticker.sv
// sample_ticker: sample-period divider for pattern_gen.
//   clk    : clock
//   reset  : asynchronous active-high reset, counter to 0
//   enable : count while high; tick can only fire while enabled
//   load   : force the counter to 0 so the first enabled cycle ticks at once
//   ckdiv  : reload value; one tick every ckdiv+1 enabled cycles
//   tick   : high on the enabled cycle where the counter is 0
module sample_ticker #(
  parameter int unsigned cw = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          load,
  input  logic [cw-1:0] ckdiv,
  output logic          tick
);

  logic [cw-1:0] cnt;

  assign tick = enable && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? ckdiv : cnt - cw'(1);
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: plays an AXI-Stream of sample words onto an output pin vector,
// one word every ckdiv+1 clocks, for count samples or until tlast.
//   clk, reset           : clock, asynchronous active-high reset
//   tdata/tvalid/tlast   : sample stream in; tready accepts a word
//   start, abort         : one-cycle playback request / immediate stop
//   ckdiv                : sample period minus one, latched on start
//   count                : samples to play, latched on start
//   idle_level           : pin value while not playing
//   dout                 : registered output pins
//   busy                 : playback in progress (PREFETCH, RUN, DONE)
//   done                 : one-cycle pulse on normal completion
//   underrun             : sticky, a sample tick found no word held
module pattern_gen
  import logicap_pkg::*;
#(
  parameter int unsigned size    = default_size,
  parameter int unsigned max_div = default_max_div,
  parameter int unsigned saddr_w = default_saddr_w
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [size-1:0]            tdata,
  input  logic                       tvalid,
  output logic                       tready,
  input  logic                       tlast,
  input  logic                       start,
  input  logic                       abort,
  input  logic [$clog2(max_div)-1:0] ckdiv,
  input  logic [saddr_w-1:0]         count,
  input  logic [size-1:0]            idle_level,
  output logic [size-1:0]            dout,
  output logic                       busy,
  output logic                       done,
  output logic                       underrun
);

  localparam int unsigned cw = $clog2(max_div);

  pattern_gen_state_t state, state_next;

  logic [saddr_w-1:0] remain;
  logic [cw-1:0]      div_r;
  logic [size-1:0]    hold_word;
  logic               hold_last;
  logic               nv;
  logic               stop;      // final word already emitted; wait for next tick
  logic               tick;
  logic               run_en;
  logic               emit;
  logic               last_emit;
  logic               xfer;

  assign run_en = (state == RUN);

  sample_ticker #(.cw(cw)) u_ticker (
    .clk    (clk),
    .reset  (reset),
    .enable (run_en),
    .load   (!run_en),
    .ckdiv  (div_r),
    .tick   (tick)
  );

  // The held word may be refilled on the same tick it is emitted, except when
  // that emission is the final sample: then nothing more is pulled upstream.
  always_comb begin
    emit      = 1'b0;
    last_emit = 1'b0;
    tready    = 1'b0;
    emit      = run_en && tick && nv;
    last_emit = emit && ((remain == saddr_w'(1)) || hold_last);
    if (state == PREFETCH || (run_en && !stop)) begin
      tready = !nv || (tick && !last_emit);
    end
    xfer = tvalid && tready;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (start) state_next = (count == '0) ? DONE : PREFETCH;
      PREFETCH: if (xfer) state_next = RUN;
      RUN:      if (tick && stop) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout      <= '0;
      remain    <= '0;
      div_r     <= '0;
      hold_word <= '0;
      hold_last <= 1'b0;
      nv        <= 1'b0;
      stop      <= 1'b0;
      underrun  <= 1'b0;
    end else if (abort) begin
      dout <= idle_level;
      nv   <= 1'b0;
      stop <= 1'b0;
    end else begin
      if (xfer) begin
        hold_word <= tdata;
        hold_last <= tlast;
        nv        <= 1'b1;
      end else if (emit) begin
        nv <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          dout <= idle_level;
          if (start) begin
            remain   <= count;
            div_r    <= ckdiv;
            underrun <= 1'b0;
            nv       <= 1'b0;
            stop     <= 1'b0;
          end
        end
        RUN: begin
          if (emit) begin
            dout   <= hold_word;
            remain <= remain - saddr_w'(1);
            if (last_emit) stop <= 1'b1;
          end else if (tick) begin
            // Missing word: hold the pins and retry on the next tick.
            if (stop) dout <= idle_level;
            else      underrun <= 1'b1;
          end
        end
        DONE:    dout <= idle_level;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed bench for pattern_gen. A small stream source feeds
// numbered words; each step checks outputs against hand-derived timelines
// counted in clock edges from the edge that samples start (k = 1).
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        start;
  logic        abort;
  logic [4:0]  ckdiv;
  logic [23:0] count;
  logic [31:0] idle_lvl;
  logic [31:0] dout;
  logic        busy;
  logic        done;
  logic        underrun;

  logic [31:0] src_words [0:15];
  int unsigned src_idx = 0;
  int unsigned src_n = 0;
  int unsigned src_last = 99;
  logic        src_clear = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  pattern_gen #(.size(32), .max_div(32), .saddr_w(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .tdata      (tdata),
    .tvalid     (tvalid),
    .tready     (tready),
    .tlast      (tlast),
    .start      (start),
    .abort      (abort),
    .ckdiv      (ckdiv),
    .count      (count),
    .idle_level (idle_lvl),
    .dout       (dout),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  assign tvalid = (src_idx < src_n);
  assign tdata  = src_words[src_idx[3:0]];
  assign tlast  = (src_idx == src_last);

  always @(posedge clk) begin
    if (src_clear) src_idx <= 0;
    else if (tvalid && tready) src_idx <= src_idx + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic new_stream(input int unsigned n, input int unsigned last, input logic [31:0] base);
    for (int i = 0; i < 16; i++) src_words[i] = base + 32'(i);
    src_n     = n;
    src_last  = last;
    src_clear = 1'b1;
    cycle();
    src_clear = 1'b0;
  endtask

  task automatic start_play(input int unsigned c, input int unsigned d);
    count = 24'(c);
    ckdiv = 5'(d);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  logic [31:0] exp_d;

  initial begin
    start = 1'b0; abort = 1'b0; count = '0; ckdiv = '0;
    idle_lvl = 32'h0000_1DE1;
    #1 reset = 1'b1;
    #2;
    chk("rst_dout", dout, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    chk("rst_tready", 32'(tready), 32'h0);
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    chk("idle_follow", dout, idle_lvl);

    // count=4, ckdiv=0, tvalid held: A..D back to back, then done + idle
    new_stream(6, 99, 32'hA000_0000);
    #1 chk("s1_idle_tready", 32'(tready), 32'h0);
    start_play(4, 0);
    chk("s1_busy_k1", 32'(busy), 32'h1);
    for (int k = 2; k <= 8; k++) begin
      cycle();
      exp_d = (k >= 3 && k <= 6) ? 32'hA000_0000 + 32'(k - 3) : idle_lvl;
      chk("s1_dout", dout, exp_d);
      chk("s1_done", 32'(done), 32'(k == 7));
      chk("s1_busy", 32'(busy), 32'(k <= 7));
    end
    chk("s1_handshakes", src_idx, 32'd4);
    chk("s1_no_underrun", 32'(underrun), 32'h0);

    // count=3, ckdiv=3: 4 cycles per word; a start while busy is ignored
    new_stream(5, 99, 32'hB000_0000);
    start_play(3, 3);
    for (int k = 2; k <= 17; k++) begin
      cycle();
      if (k == 5) begin count = 24'd1; start = 1'b1; end
      if (k == 6) start = 1'b0;
      if (k >= 3 && k <= 6)       exp_d = 32'hB000_0000;
      else if (k >= 7 && k <= 10) exp_d = 32'hB000_0001;
      else if (k >= 11 && k <= 14) exp_d = 32'hB000_0002;
      else                        exp_d = idle_lvl;
      chk("s2_dout", dout, exp_d);
      chk("s2_done", 32'(done), 32'(k == 15));
      if (k == 4) begin #1; chk("s2_tready_full", 32'(tready), 32'h0); end
    end
    chk("s2_handshakes", src_idx, 32'd3);
    chk("s2_no_underrun", 32'(underrun), 32'h0);

    // count=8 with tlast on the second word: stops after 2 samples
    new_stream(8, 1, 32'hC000_0000);
    start_play(8, 0);
    for (int k = 2; k <= 8; k++) begin
      cycle();
      if (k == 3)      exp_d = 32'hC000_0000;
      else if (k == 4) exp_d = 32'hC000_0001;
      else             exp_d = idle_lvl;
      chk("s3_dout", dout, exp_d);
      chk("s3_done", 32'(done), 32'(k == 5));
      if (k == 4) begin #1; chk("s3_tready_last", 32'(tready), 32'h0); end
    end
    chk("s3_handshakes", src_idx, 32'd2);
    chk("s3_tready_pending", 32'(tready), 32'h0);

    // tvalid low for 5 cycles mid-run: underrun, pins hold, nothing skipped
    new_stream(2, 99, 32'hD000_0000);
    start_play(5, 0);
    for (int k = 2; k <= 14; k++) begin
      cycle();
      if (k == 8) src_n = 5;
      if (k == 3)                exp_d = 32'hD000_0000;
      else if (k >= 4 && k <= 9) exp_d = 32'hD000_0001;
      else if (k == 10)          exp_d = 32'hD000_0002;
      else if (k == 11)          exp_d = 32'hD000_0003;
      else if (k == 12)          exp_d = 32'hD000_0004;
      else                       exp_d = idle_lvl;
      chk("s4_dout", dout, exp_d);
      chk("s4_underrun", 32'(underrun), 32'(k >= 5));
      chk("s4_done", 32'(done), 32'(k == 13));
    end
    chk("s4_handshakes", src_idx, 32'd5);

    // abort on a tick in RUN, then a clean replay
    new_stream(6, 99, 32'hE000_0000);
    start_play(4, 0);
    cycle();
    chk("s5_underrun_cleared", 32'(underrun), 32'h0);
    cycle();
    chk("s5_dout_k3", dout, 32'hE000_0000);
    cycle();
    chk("s5_dout_k4", dout, 32'hE000_0001);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("s5_abort_dout", dout, idle_lvl);
    chk("s5_abort_busy", 32'(busy), 32'h0);
    #1 chk("s5_abort_tready", 32'(tready), 32'h0);
    for (int k = 5; k <= 8; k++) begin
      chk("s5_abort_no_done", 32'(done), 32'h0);
      cycle();
    end
    new_stream(3, 99, 32'hF000_0000);
    start_play(2, 0);
    for (int k = 2; k <= 6; k++) begin
      cycle();
      if (k == 3)      exp_d = 32'hF000_0000;
      else if (k == 4) exp_d = 32'hF000_0001;
      else             exp_d = idle_lvl;
      chk("s5_replay_dout", dout, exp_d);
      chk("s5_replay_done", 32'(done), 32'(k == 5));
    end

    // abort beats start in IDLE; count=0 goes straight to DONE
    new_stream(3, 99, 32'h1100_0000);
    count = 24'd2; start = 1'b1; abort = 1'b1;
    cycle();
    start = 1'b0; abort = 1'b0;
    chk("s6_abort_wins", 32'(busy), 32'h0);
    start_play(0, 0);
    chk("s6_zero_done", 32'(done), 32'h1);
    chk("s6_zero_busy", 32'(busy), 32'h1);
    #1 chk("s6_zero_tready", 32'(tready), 32'h0);
    cycle();
    chk("s6_zero_done_end", 32'(done), 32'h0);
    chk("s6_zero_idle", 32'(busy), 32'h0);
    chk("s6_zero_handshakes", src_idx, 32'd0);

    // idle_level reaches the pins one cycle later
    idle_lvl = 32'h0BAD_CAFE;
    #1 chk("s7_idle_old", dout, 32'h0000_1DE1);
    cycle();
    chk("s7_idle_new", dout, 32'h0BAD_CAFE);

    // asynchronous reset in the middle of RUN
    idle_lvl = 32'h1234_5678;
    new_stream(1, 99, 32'h7700_0000);
    start_play(4, 0);
    for (int k = 2; k <= 5; k++) cycle();
    chk("s8_pre_dout", dout, 32'h7700_0000);
    chk("s8_pre_underrun", 32'(underrun), 32'h1);
    #1 chk("s8_pre_tready", 32'(tready), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("s8_rst_dout", dout, 32'h0);
    chk("s8_rst_busy", 32'(busy), 32'h0);
    chk("s8_rst_done", 32'(done), 32'h0);
    chk("s8_rst_underrun", 32'(underrun), 32'h0);
    chk("s8_rst_tready", 32'(tready), 32'h0);
    cycle();
    reset = 1'b0;
    cycle();
    chk("s8_post_idle", dout, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
